// File: rtl/idu32_encoder.sv
// idu32_encoder: streaming RV32I instruction encoder.
// Packs opcode, register, funct and immediate fields into 32-bit instruction
// words for building instruction-memory images. Each word is tagged with its
// target address. Immediates that cannot be represented in the selected format
// are replaced by ERR_NOP and flagged.
//
// Ports:
//   clk, rstn            clock (rising edge), asynchronous active-low reset
//   flush                drop in-flight words, reload address to BASE_ADDR
//   in_valid/in_ready    input field handshake
//   fmt                  0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
//   opcode, funct3, funct7, rd, rs1, rs2, imm   instruction fields
//   out_valid/out_ready  output word handshake
//   out_inst, out_addr   encoded word and its address
//   out_err              word was replaced by ERR_NOP
//   err_cnt              saturating count of error words transferred
`timescale 1ns/1ps
module idu32_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter logic [31:0] ERR_NOP   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic signed [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic [7:0]  err_cnt
);

  // True when the immediate cannot be represented in the chosen format.
  function automatic logic range_err(input logic [2:0] f, input logic signed [31:0] v);
    logic e;
    case (f)
      3'd0:        e = 1'b0;
      3'd1, 3'd2:  e = !((&v[31:11]) || !(|v[31:11]));
      3'd3:        e = !((&v[31:12]) || !(|v[31:12])) || v[0];
      3'd4:        e = |v[11:0];
      3'd5:        e = !((&v[31:20]) || !(|v[31:20])) || v[0];
      default:     e = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] pack(
    input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
    input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
    input logic [4:0] s2, input logic signed [31:0] v);
    logic [31:0] w;
    case (f)
      3'd0:    w = {f7, s2, s1, f3, d, op};
      3'd1:    w = {v[11:0], s1, f3, d, op};
      3'd2:    w = {v[11:5], s2, s1, f3, v[4:0], op};
      3'd3:    w = {v[12], v[10:5], s2, s1, f3, v[4:1], v[11], op};
      3'd4:    w = {v[31:12], d, op};
      3'd5:    w = {v[20], v[10:1], v[11], v[19:12], d, op};
      default: w = 32'd0;
    endcase
    return w;
  endfunction

  logic        vld_p1, vld_p2;
  logic [2:0]  fmt_p1, funct3_p1;
  logic [6:0]  opcode_p1, funct7_p1;
  logic [4:0]  rd_p1, rs1_p1, rs2_p1;
  logic signed [31:0] imm_p1;
  logic        err_p1;
  logic [31:0] inst_p2, addr_p2, addr_cnt;
  logic        err_p2;
  logic [7:0]  err_cnt_q;

  logic out_fire, load_p2, adv_p1, load_p1, in_fire;

  assign out_fire = vld_p2 && out_ready;
  assign load_p2  = !vld_p2 || out_fire;
  assign adv_p1   = vld_p1 && load_p2;
  assign load_p1  = !vld_p1 || adv_p1;
  // rstn is folded in so the encoder refuses input while held in reset.
  assign in_ready = rstn && !flush && load_p1;
  assign in_fire  = in_valid && in_ready;

  // ---- stage 1: register fields and range check ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p1 <= 1'b0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (load_p1) begin
      vld_p1 <= in_fire;
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      fmt_p1    <= fmt;
      opcode_p1 <= opcode;
      funct3_p1 <= funct3;
      funct7_p1 <= funct7;
      rd_p1     <= rd;
      rs1_p1    <= rs1;
      rs2_p1    <= rs2;
      imm_p1    <= imm;
      err_p1    <= range_err(fmt, imm);
    end
  end

  // ---- stage 2: packed word, error flag, address ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p2   <= 1'b0;
      inst_p2  <= 32'd0;
      addr_p2  <= BASE_ADDR;
      err_p2   <= 1'b0;
      addr_cnt <= BASE_ADDR;
    end else if (flush) begin
      vld_p2   <= 1'b0;
      addr_cnt <= BASE_ADDR;
    end else if (load_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        inst_p2  <= err_p1 ? ERR_NOP
                           : pack(fmt_p1, opcode_p1, funct3_p1, funct7_p1,
                                  rd_p1, rs1_p1, rs2_p1, imm_p1);
        err_p2   <= err_p1;
        addr_p2  <= addr_cnt;
        addr_cnt <= addr_cnt + 32'd4;
      end
    end
  end

  // Counted on transfer, so a flushed error word is never counted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_cnt_q <= 8'd0;
    end else if (!flush && out_fire && err_p2 && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign out_valid = vld_p2;
  assign out_inst  = inst_p2;
  assign out_addr  = addr_p2;
  assign out_err   = err_p2;
  assign err_cnt   = err_cnt_q;

endmodule
